// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter: tag width default,
// data width and the broadcast source encoding.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH_BIT_DEF = 4;
  localparam int CDB_DATA_W        = 32;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  // Round-robin pick: on a tie the source that did not win last time goes next.
  function automatic cdb_src_e rr_pick(input logic alu_ne, input logic lsb_ne,
                                       input cdb_src_e last);
    cdb_src_e pick;
    if (alu_ne && lsb_ne) begin
      pick = (last == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
    end else if (lsb_ne) begin
      pick = CDB_SRC_LSB;
    end else begin
      pick = CDB_SRC_ALU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Small per-producer result FIFO. Head is presented combinationally on dout_o;
// flush clears pointers and count and wins over push/pop.
module result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign empty_o = (count_q == {CW{1'b0}});
  assign full_o  = (count_q == CW'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];

  // Overflow/underflow are blocked here as well as by the caller.
  assign push_s = push_i && !full_o;
  assign pop_s  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between the ALU and LSB result
// FIFOs; one registered broadcast per cycle, frozen by rdy_in, cleared by flush_in.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF,
  parameter int QDEPTH        = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     alu_valid,
  input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
  input  logic [31:0]              alu_value,
  output logic                     alu_ready,
  input  logic                     lsb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,
  output logic                     lsb_ready,
  output logic                     cdb_valid,
  output logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  output logic [31:0]              cdb_value,
  output logic                     cdb_src
);

  localparam int EW = ROB_WIDTH_BIT + CDB_DATA_W;

  logic [EW-1:0] alu_dout_s, lsb_dout_s, gnt_entry_s;
  logic          alu_empty_s, alu_full_s, lsb_empty_s, lsb_full_s;
  logic          alu_push_s, lsb_push_s, alu_pop_s, lsb_pop_s, flush_s, active_s;
  logic          grant_vld_s;
  cdb_src_e      grant_src_s;

  logic                     cdb_valid_q, cdb_valid_d;
  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [31:0]              cdb_value_q, cdb_value_d;
  cdb_src_e                 cdb_src_q, cdb_src_d;
  cdb_src_e                 last_grant_q, last_grant_d;

  assign alu_ready = rdy_in && !alu_full_s;
  assign lsb_ready = rdy_in && !lsb_full_s;
  assign flush_s   = rdy_in && flush_in;
  assign active_s  = rdy_in && !flush_in;

  assign alu_push_s = alu_valid && alu_ready && !flush_in;
  assign lsb_push_s = lsb_valid && lsb_ready && !flush_in;

  assign grant_vld_s = !alu_empty_s || !lsb_empty_s;
  assign grant_src_s = rr_pick(!alu_empty_s, !lsb_empty_s, last_grant_q);
  assign alu_pop_s   = active_s && grant_vld_s && (grant_src_s == CDB_SRC_ALU);
  assign lsb_pop_s   = active_s && grant_vld_s && (grant_src_s == CDB_SRC_LSB);
  assign gnt_entry_s = (grant_src_s == CDB_SRC_LSB) ? lsb_dout_s : alu_dout_s;

  result_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_alu_fifo (
    .clk_i(clk_in), .rst_ni(rst_in), .flush_i(flush_s),
    .push_i(alu_push_s), .pop_i(alu_pop_s), .din_i({alu_rob_id, alu_value}),
    .dout_o(alu_dout_s), .empty_o(alu_empty_s), .full_o(alu_full_s)
  );

  result_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_lsb_fifo (
    .clk_i(clk_in), .rst_ni(rst_in), .flush_i(flush_s),
    .push_i(lsb_push_s), .pop_i(lsb_pop_s), .din_i({lsb_rob_id, lsb_value}),
    .dout_o(lsb_dout_s), .empty_o(lsb_empty_s), .full_o(lsb_full_s)
  );

  // Data outputs keep their last broadcast value when no grant is made.
  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (!rdy_in) begin
      cdb_valid_d = cdb_valid_q;
    end else if (flush_in) begin
      cdb_valid_d  = 1'b0;
      last_grant_d = CDB_SRC_LSB;
    end else if (grant_vld_s) begin
      cdb_valid_d  = 1'b1;
      cdb_rob_id_d = gnt_entry_s[EW-1 -: ROB_WIDTH_BIT];
      cdb_value_d  = gnt_entry_s[CDB_DATA_W-1:0];
      cdb_src_d    = grant_src_s;
      last_grant_d = grant_src_s;
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= {ROB_WIDTH_BIT{1'b0}};
      cdb_value_q  <= 32'd0;
      cdb_src_q    <= CDB_SRC_ALU;
      last_grant_q <= CDB_SRC_LSB;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized, model-checked bench for cdb_arbiter: a queue-based reference of the
// two result FIFOs and round-robin broadcast, plus directed scenario tasks.
module tb_cdb_arbiter;

  localparam int RW = 4;
  localparam int QD = 2;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, flush_in;
  logic          alu_valid, lsb_valid, alu_ready, lsb_ready;
  logic [RW-1:0] alu_rob_id, lsb_rob_id, cdb_rob_id;
  logic [31:0]   alu_value, lsb_value, cdb_value;
  logic          cdb_valid, cdb_src;

  cdb_arbiter #(.ROB_WIDTH_BIT(RW), .QDEPTH(QD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [RW+31:0] aq[$], lq[$];
  logic           m_valid, m_src, m_lg;
  logic [RW-1:0]  m_rob;
  logic [31:0]    m_val;
  logic           exp_ar, exp_lr, obs_ar, obs_lr;

  task automatic model_reset();
    aq.delete(); lq.delete();
    m_valid = 1'b0; m_src = 1'b0; m_rob = '0; m_val = 32'd0; m_lg = 1'b1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    alu_valid = 1'b0; lsb_valid = 1'b0;
    alu_rob_id = '0; lsb_rob_id = '0; alu_value = 32'd0; lsb_value = 32'd0;
    model_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
  endtask

  // Drive one cycle of inputs, sample readies, clock, and advance the model.
  task automatic tick(input logic av, input logic [RW-1:0] aid, input logic [31:0] aval,
                      input logic lv, input logic [RW-1:0] lid, input logic [31:0] lval,
                      input logic rdy, input logic fl);
    logic [RW+31:0] e;
    logic           g;
    alu_valid = av; alu_rob_id = aid; alu_value = aval;
    lsb_valid = lv; lsb_rob_id = lid; lsb_value = lval;
    rdy_in = rdy; flush_in = fl;
    #1;
    obs_ar = alu_ready; obs_lr = lsb_ready;
    exp_ar = rdy && (aq.size() < QD);
    exp_lr = rdy && (lq.size() < QD);
    @(posedge clk_in);
    if (!rdy) begin
      g = 1'b0;
    end else if (fl) begin
      aq.delete(); lq.delete(); m_valid = 1'b0; m_lg = 1'b1;
    end else begin
      if (aq.size() > 0 || lq.size() > 0) begin
        if (aq.size() > 0 && lq.size() > 0) g = ~m_lg;
        else g = (lq.size() > 0);
        e = g ? lq.pop_front() : aq.pop_front();
        m_valid = 1'b1; m_src = g; m_lg = g;
        m_rob = e[RW+31:32]; m_val = e[31:0];
      end else begin
        m_valid = 1'b0;
      end
      if (av && exp_ar) aq.push_back({aid, aval});
      if (lv && exp_lr) lq.push_back({lid, lval});
    end
    #1;
  endtask

  task automatic tick_idle();
    tick(1'b0, '0, 32'd0, 1'b0, '0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
    #2;
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b0, 1'b0, {RW{1'b0}}, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b s=%b id=%h val=%h want all zero",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    end
    vectors++;
    if ({alu_ready, lsb_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got %b%b want 11", alu_ready, lsb_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    tick(1'b1, 4'd3, 32'h1234, 1'b0, '0, 32'd0, 1'b1, 1'b0);
    vectors++;
    if (cdb_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_no_bypass: got valid=%b want 0", cdb_valid);
    end
    tick_idle();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 1'b0, 4'd3, 32'h1234}) begin
      miscompares++;
      $display("FAIL single_bcast: got v=%b s=%b id=%h val=%h want 1/0/3/1234",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    end
    tick_idle();
    vectors++;
    if ({cdb_valid, cdb_rob_id, cdb_value} !== {1'b0, 4'd3, 32'h1234}) begin
      miscompares++;
      $display("FAIL single_pulse: got v=%b id=%h val=%h want 0/3/1234 (held)",
               cdb_valid, cdb_rob_id, cdb_value);
    end
  endtask

  task automatic test_tie();
    logic [31:0] va, vl;
    do_reset();
    va = $urandom; vl = $urandom;
    tick(1'b1, 4'd1, va, 1'b1, 4'd2, vl, 1'b1, 1'b0);
    tick_idle();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 1'b0, 4'd1, va}) begin
      miscompares++;
      $display("FAIL tie_first: got v=%b s=%b id=%h val=%h want 1/0/1/%h",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value, va);
    end
    tick_idle();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 1'b1, 4'd2, vl}) begin
      miscompares++;
      $display("FAIL tie_second: got v=%b s=%b id=%h val=%h want 1/1/2/%h",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value, vl);
    end
  endtask

  task automatic test_fill_and_alternate();
    logic saw_full, prev_v, prev_s;
    do_reset();
    saw_full = 1'b0; prev_v = 1'b0; prev_s = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c < 10) tick(1'b1, RW'($urandom), $urandom, 1'b1, RW'($urandom), $urandom, 1'b1, 1'b0);
      else tick_idle();
      if (!obs_lr) saw_full = 1'b1;
      vectors++;
      if ({obs_ar, obs_lr} !== {exp_ar, exp_lr}) begin
        miscompares++;
        $display("FAIL fill_ready c=%0d: got %b%b want %b%b", c, obs_ar, obs_lr, exp_ar, exp_lr);
      end
      vectors++;
      if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {m_valid, m_src, m_rob, m_val}) begin
        miscompares++;
        $display("FAIL fill_model c=%0d: got %b/%b/%h/%h want %b/%b/%h/%h", c, cdb_valid,
                 cdb_src, cdb_rob_id, cdb_value, m_valid, m_src, m_rob, m_val);
      end
      if (c >= 1 && c < 10 && prev_v && cdb_valid) begin
        vectors++;
        if (cdb_src === prev_s) begin
          miscompares++;
          $display("FAIL alternate c=%0d: got src=%b twice, want alternation", c, cdb_src);
        end
      end
      prev_v = cdb_valid; prev_s = cdb_src;
    end
    vectors++;
    if (saw_full !== 1'b1) begin
      miscompares++; $display("FAIL lsb_full_seen: got %b want 1", saw_full);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 4; c++)
      tick(1'b1, RW'($urandom), $urandom, 1'b1, RW'($urandom), $urandom, 1'b1, 1'b0);
    vectors++;
    if (cdb_valid !== 1'b1) begin
      miscompares++; $display("FAIL flush_pre_valid: got %b want 1", cdb_valid);
    end
    tick(1'b1, 4'd9, 32'hdead, 1'b1, 4'd10, 32'hbeef, 1'b1, 1'b1);
    vectors++;
    if (cdb_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_valid: got %b want 0", cdb_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick_idle();
      if (c == 0) begin
        vectors++;
        if ({obs_ar, obs_lr} !== 2'b11) begin
          miscompares++; $display("FAIL flush_ready: got %b%b want 11", obs_ar, obs_lr);
        end
      end
      vectors++;
      if (cdb_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_stale c=%0d: got valid=%b id=%h want 0", c,
                                cdb_valid, cdb_rob_id);
      end
    end
  endtask

  task automatic test_freeze();
    logic [RW+33:0] snap;
    do_reset();
    tick(1'b1, 4'd5, $urandom, 1'b1, 4'd6, $urandom, 1'b1, 1'b0);
    tick(1'b1, 4'd7, $urandom, 1'b0, '0, 32'd0, 1'b1, 1'b0);
    snap = {cdb_valid, cdb_src, cdb_rob_id, cdb_value};
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 4'd11, $urandom, 1'b1, 4'd12, $urandom, 1'b0, (c == 1));
      vectors++;
      if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== snap) begin
        miscompares++; $display("FAIL freeze_hold c=%0d: got %h want %h", c,
                                {cdb_valid, cdb_src, cdb_rob_id, cdb_value}, snap);
      end
      vectors++;
      if ({obs_ar, obs_lr} !== 2'b00) begin
        miscompares++; $display("FAIL freeze_ready c=%0d: got %b%b want 00", c, obs_ar, obs_lr);
      end
    end
    tick_idle();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob_id} !== {1'b1, 1'b1, 4'd6}) begin
      miscompares++; $display("FAIL freeze_resume: got v=%b s=%b id=%h want 1/1/6",
                              cdb_valid, cdb_src, cdb_rob_id);
    end
    tick_idle();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {m_valid, m_src, m_rob, m_val}) begin
      miscompares++; $display("FAIL freeze_drain: got %b/%b/%h want %b/%b/%h",
                              cdb_valid, cdb_src, cdb_rob_id, m_valid, m_src, m_rob);
    end
  endtask

  task automatic test_random();
    logic rdy, fl;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      tick(1'($urandom_range(0, 1)), RW'($urandom), $urandom,
           1'($urandom_range(0, 1)), RW'($urandom), $urandom, rdy, fl);
      vectors++;
      if ({obs_ar, obs_lr} !== {exp_ar, exp_lr}) begin
        miscompares++;
        $display("FAIL rand_ready c=%0d: got %b%b want %b%b", c, obs_ar, obs_lr, exp_ar, exp_lr);
      end
      vectors++;
      if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {m_valid, m_src, m_rob, m_val}) begin
        miscompares++;
        $display("FAIL rand_model c=%0d: got %b/%b/%h/%h want %b/%b/%h/%h", c, cdb_valid,
                 cdb_src, cdb_rob_id, cdb_value, m_valid, m_src, m_rob, m_val);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 4'd13, 32'h55aa, 1'b1, 4'd14, 32'h1, 1'b1, 1'b0);
    tick_idle();
    #2 rst_in = 1'b0;
    #1;
    vectors++;
    if ({cdb_valid, cdb_rob_id, cdb_value} !== {1'b0, {RW{1'b0}}, 32'd0}) begin
      miscompares++; $display("FAIL async_reset: got v=%b id=%h val=%h want 0/0/0",
                              cdb_valid, cdb_rob_id, cdb_value);
    end
    model_reset();
    @(posedge clk_in); #1 rst_in = 1'b1;
    tick_idle();
    vectors++;
    if (cdb_valid !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_empty: got valid=%b want 0", cdb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fill_and_alternate();
    test_flush();
    test_freeze();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
